// File: rtl/rv_isa_pkg.sv
// rv_isa_pkg: RV32I format codes and opcode constants shared by encoder and decoder
package rv_isa_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: small circular FIFO whose output holds the last popped entry while empty
module sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_rdata
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_cnt;
  logic [WIDTH-1:0] r_last;
  logic             w_push;
  logic             w_pop;

  assign o_full  = r_cnt == (AW+1)'(DEPTH);
  assign o_empty = r_cnt == '0;
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_rdata = o_empty ? r_last : r_mem[r_rd];

  // storage array needs no reset: it is only observed through a nonzero occupancy
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_wdata;
  end

  // pointers, occupancy and the held copy of the most recently popped entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_cnt  <= '0;
      r_last <= '0;
    end else begin
      r_wr   <= r_wr + AW'(w_push);
      r_rd   <= r_rd + AW'(w_pop);
      r_cnt  <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
      r_last <= w_pop ? r_mem[r_rd] : r_last;
    end
  end

endmodule

// File: rtl/inst_encoder.sv
// inst_encoder: packs RV32I fields into instruction words and streams them from a FIFO
module inst_encoder
  import rv_isa_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_fmt,
  input  logic [6:0]       req_opcode,
  input  logic [4:0]       req_rd,
  input  logic [4:0]       req_rs1,
  input  logic [4:0]       req_rs2,
  input  logic [2:0]       req_funct3,
  input  logic [6:0]       req_funct7,
  input  logic [31:0]      req_imm,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [31:0]      inst_word,
  output logic             inst_err,
  output logic [CNT_W-1:0] enc_count
);

  // returns {err, word}; out-of-range immediates still encode their truncated bits
  function automatic logic [32:0] encode(
    input logic [2:0]  fmt,
    input logic [6:0]  op,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [2:0]  f3,
    input logic [6:0]  f7,
    input logic [31:0] imm
  );
    logic fit12, fit13, fit21;
    fit12 = imm == {{20{imm[11]}}, imm[11:0]};
    fit13 = imm == {{19{imm[12]}}, imm[12:0]};
    fit21 = imm == {{11{imm[20]}}, imm[20:0]};
    case (fmt)
      FMT_R:   return {1'b0, f7, rs2, rs1, f3, rd, op};
      FMT_I:   return {~fit12, imm[11:0], rs1, f3, rd, op};
      FMT_S:   return {~fit12, imm[11:5], rs2, rs1, f3, imm[4:0], op};
      FMT_B:   return {~fit13 | imm[0], imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
      FMT_U:   return {|imm[11:0], imm[31:12], rd, op};
      FMT_J:   return {~fit21 | imm[0], imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
      default: return {1'b1, 32'b0};
    endcase
  endfunction

  logic        w_full;
  logic        w_empty;
  logic        w_accept;
  logic [32:0] w_enc;
  logic [32:0] w_head;
  logic [CNT_W-1:0] r_count;

  assign req_ready  = ~w_full;
  assign w_accept   = req_valid & ~w_full;
  assign w_enc      = encode(req_fmt, req_opcode, req_rd, req_rs1, req_rs2, req_funct3, req_funct7, req_imm);
  assign inst_valid = ~w_empty;
  assign inst_err   = w_head[32];
  assign inst_word  = w_head[31:0];
  assign enc_count  = r_count;

  sync_fifo #(.WIDTH(33), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_accept),
    .i_wdata (w_enc),
    .i_pop   (inst_ready),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_rdata (w_head)
  );

  // counts every accepted request, flagged or not, wrapping at 2^CNT_W
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_count <= '0;
    else        r_count <= r_count + CNT_W'(w_accept);
  end

endmodule
